serial_frame_scanner: RTL and testbench
=======================================

SERIAL_FRAME_SCANNER -- requirements
Module: serial_frame_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning frame width in bits (legal range 3..32).
REQ-002 SHALL have parameter CNT_W, default 4, meaning match counter width in bits (legal range 1..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  a frame is offered on in_data.
REQ-006 SHALL have port in_data  input  WIDTH  the frame, scanned MSB first.
REQ-007 SHALL have port in_ready  output  1  the block can accept a frame this cycle.
REQ-008 SHALL have port ser_bit  output  1  the bit being presented to the detector this cycle.
REQ-009 SHALL have port det_flag  output  1  Moore detector output, high while the detector is in state D.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking the frame result as valid.
REQ-011 SHALL have port match_count  output  CNT_W  number of "100" detections in the last completed frame.

Function
REQ-012 SHALL implement the controller FSM with states IDLE, SHIFT and REPORT.
REQ-013 SHALL drive in_ready high only in IDLE; accept = in_valid and in_ready.
REQ-014 On accept in IDLE, SHALL load in_data into the shift register, load the bit counter to WIDTH, clear the running count, reset the detector to A and go to SHIFT; if there is no accept, SHALL stay in IDLE.
REQ-015 In SHIFT, SHALL present ser_bit = shift register MSB, shift left by one, advance the detector on ser_bit and decrement the bit counter, once per cycle.
REQ-016 SHALL implement the detector as a Moore FSM with A→(x?B:A), B→(x?B:C), C→(x?B:D), D→(x?B:A); det_flag = (detector state == D).
REQ-017 SHALL increment the running count in the same cycle that the detector's next state is D, saturating at 2^CNT_W−1 with no wrap.
REQ-018 SHALL leave SHIFT for REPORT after exactly WIDTH shift cycles (bit counter reaching 1 at the transition).
REQ-019 In REPORT, SHALL assert done for exactly one cycle, update match_count with the final running count in that cycle, and return to IDLE on the next cycle.
REQ-020 SHALL hold match_count stable from REPORT until the next REPORT.
REQ-021 Latency: for accept at cycle T, bits SHALL appear on ser_bit in cycles T+1..T+WIDTH and done SHALL occur at T+WIDTH+1; throughput SHALL be one frame per WIDTH+2 cycles.
REQ-022 SHALL ignore in_valid and in_data outside IDLE, with no buffering of frames.
REQ-023 SHALL hold the detector state in IDLE and REPORT, so det_flag keeps its last value until the next accept resets the detector to A.
REQ-024 ser_bit SHALL be 0 outside SHIFT.

Reset
REQ-025 While rst is high at a clock edge, SHALL set the controller to IDLE, the detector to A, the shift register, bit counter, running count and match_count to 0, and done to 0.
REQ-026 After reset, SHALL drive in_ready = 1, det_flag = 0, ser_bit = 0, done = 0 and match_count = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame, produce no done pulse and leave match_count at 0.
REQ-028 rst SHALL take priority over accept in the same cycle.

Verification
REQ-029 With WIDTH=8 and CNT_W=4, accepting 8'b1001_0010 SHALL produce bits 1,0,0,1,0,0,1,0 on ser_bit, det_flag high after bits 3 and 6, and done at T+9 with match_count = 2.
REQ-030 Accepting 8'hFF SHALL give match_count = 0 and det_flag never high; accepting 8'b1000_0000 SHALL give match_count = 1.
REQ-031 With CNT_W=1, accepting 8'b1001_0000 SHALL give match_count = 1, showing saturation with no wrap to 0.
REQ-032 Holding in_valid high with frames 8'h92 then 8'h80 SHALL give accepts at T and T+10, done pulses at T+9 and T+19 with counts 2 and 1, and in_ready low during T+1..T+9.
REQ-033 Asserting rst at T+4 of a frame SHALL give no done pulse, match_count = 0 and in_ready = 1 on the cycle after rst is released.
REQ-034 Asserting in_valid during SHIFT with a different word SHALL leave the current frame's result unchanged, and that word SHALL not be accepted until the block returns to IDLE.

Source files
------------

// File: rtl/serial_frame_scanner.sv
// serial_frame_scanner: serialises frames MSB first and counts "100" detections per frame
module serial_frame_scanner #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             det_flag,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;
    localparam logic [1:0] DA = 2'd0;
    localparam logic [1:0] DB = 2'd1;
    localparam logic [1:0] DC = 2'd2;
    localparam logic [1:0] DD = 2'd3;
    localparam int BW = $clog2(WIDTH + 1);
    logic [1:0]       state;
    logic [1:0]       det;
    logic [1:0]       det_nxt;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0]    cnt;
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_nxt;
    logic             accept;
    logic             last;
    assign in_ready = state == IDLE;
    assign accept   = in_valid && in_ready;
    assign ser_bit  = state == SHIFT && sr[WIDTH-1];
    assign det_flag = det == DD;
    assign done     = state == REPORT;
    // detector next state and saturating running count for the bit presented this cycle
    always_comb begin
        det_nxt = ser_bit ? DB : (det == DB ? DC : det == DC ? DD : DA);
        run_nxt = (det_nxt == DD && run != '1) ? run + 1'b1 : run;
        last    = cnt == BW'(1);
    end
    // controller: load on accept, shift WIDTH cycles, publish result for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            det         <= DA;
            sr          <= '0;
            cnt         <= '0;
            run         <= '0;
            match_count <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                sr    <= in_data;
                cnt   <= BW'(WIDTH);
                run   <= '0;
                det   <= DA;
                state <= SHIFT;
            end
        end else if (state == SHIFT) begin
            sr  <= {sr[WIDTH-2:0], 1'b0};
            det <= det_nxt;
            run <= run_nxt;
            cnt <= cnt - 1'b1;
            if (last) begin
                state       <= REPORT;
                match_count <= run_nxt;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_frame_scanner.sv
// tb_serial_frame_scanner: directed checks of serialisation, detection, counting and reset
module tb_serial_frame_scanner;
    logic       clk = 0;
    logic       rst = 1;
    logic       in_valid = 0;
    logic [7:0] in_data = '0;
    logic       in_ready, ser_bit, det_flag, done;
    logic [3:0] match_count;
    logic       in_ready1, ser_bit1, det_flag1, done1;
    logic [0:0] match_count1;
    int         checks = 0;
    int         failures = 0;

    serial_frame_scanner #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ser_bit(ser_bit), .det_flag(det_flag),
        .done(done), .match_count(match_count)
    );

    serial_frame_scanner #(.WIDTH(8), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .ser_bit(ser_bit1), .det_flag(det_flag1),
        .done(done1), .match_count(match_count1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // accept w at cycle T, hold in_valid high with jd during the frame, check T..T+10
    task automatic send(input logic [7:0] w, input logic [7:0] jd, input int e4, input int e1,
                        input logic [7:0] mask, input logic edet);
        in_valid = 1;
        in_data  = w;
        check($sformatf("rdy_T_%0h", w), in_ready, 1);
        check($sformatf("ser_T_%0h", w), ser_bit, 0);
        tick;
        in_data = jd;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ser_%0h_%0d", w, i), ser_bit, w[7-i]);
            check($sformatf("det_%0h_%0d", w, i), det_flag, mask[7-i]);
            check($sformatf("rdy_%0h_%0d", w, i), in_ready, 0);
            check($sformatf("done_%0h_%0d", w, i), done, 0);
            tick;
        end
        check($sformatf("done_T9_%0h", w), done, 1);
        check($sformatf("done1_T9_%0h", w), done1, 1);
        check($sformatf("mc_T9_%0h", w), match_count, e4);
        check($sformatf("mc1_T9_%0h", w), match_count1, e1);
        check($sformatf("det_T9_%0h", w), det_flag, edet);
        check($sformatf("rdy_T9_%0h", w), in_ready, 0);
        check($sformatf("ser_T9_%0h", w), ser_bit, 0);
        tick;
        check($sformatf("done_T10_%0h", w), done, 0);
        check($sformatf("rdy_T10_%0h", w), in_ready, 1);
        check($sformatf("mc_T10_%0h", w), match_count, e4);
        check($sformatf("mc1_T10_%0h", w), match_count1, e1);
        check($sformatf("det_T10_%0h", w), det_flag, edet);
    endtask

    initial begin
        tick;
        tick;
        check("rst_rdy", in_ready, 1);
        check("rst_det", det_flag, 0);
        check("rst_ser", ser_bit, 0);
        check("rst_done", done, 0);
        check("rst_mc", match_count, 0);
        rst = 0;
        send(8'h92, 8'h92, 2, 1, 8'h12, 0);
        send(8'h80, 8'h55, 1, 1, 8'h10, 0);
        send(8'hFF, 8'h00, 0, 0, 8'h00, 0);
        send(8'h90, 8'hAA, 2, 1, 8'h12, 0);
        send(8'h04, 8'hFF, 1, 1, 8'h00, 1);
        in_data = 8'h92;
        tick;
        in_valid = 0;
        tick;
        tick;
        tick;
        check("abort_shift_rdy", in_ready, 0);
        rst = 1;
        in_valid = 1;
        in_data = 8'h80;
        tick;
        rst = 0;
        in_valid = 0;
        check("abort_rdy", in_ready, 1);
        check("abort_mc", match_count, 0);
        check("abort_done", done, 0);
        check("abort_det", det_flag, 0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("abort_nodone_%0d", i), done, 0);
            check($sformatf("abort_noser_%0d", i), ser_bit, 0);
            tick;
        end
        rst = 1;
        in_valid = 1;
        in_data = 8'hFF;
        tick;
        rst = 0;
        in_valid = 0;
        check("rstprio_rdy", in_ready, 1);
        check("rstprio_ser", ser_bit, 0);
        tick;
        check("rstprio_idle", in_ready, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
